// File: rtl/alu_test2.sv
// alu_test2 -- registered 64-bit ALU with flags.
//
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst    : asynchronous active-high reset, clears all outputs
//   a, b   : operands; b[5:0] doubles as the shift amount
//   Cin    : adder carry-in
//   sel    : sel[4:2] operation, sel[1] inverts B, sel[0] inverts A
//   out    : registered result F
//   cOut   : registered adder carry-out
//   status : registered flags {V, C, N, Z}
module alu_test2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic [4:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             cOut,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NOP0 = 3'b010,
    OP_XOR  = 3'b011,
    OP_ADD  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SLL  = 3'b110,
    OP_NOP1 = 3'b111
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] a_op;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  logic [WIDTH-1:0] out_d, out_q;
  logic             c_d, c_q;
  logic             v_d;
  logic [3:0]       status_d, status_q;

  assign op    = op_e'(sel[4:2]);
  assign a_op  = sel[0] ? ~a : a;
  assign b_op  = sel[1] ? ~b : b;
  assign shamt = b[SHW-1:0];

  // Unsigned WIDTH+1 bit sum; the top bit is the carry-out.
  assign sum = {1'b0, a_op} + {1'b0, b_op} + {{WIDTH{1'b0}}, Cin};

  always_comb begin
    out_d = '0;
    c_d   = 1'b0;
    v_d   = 1'b0;
    unique case (op)
      OP_AND: out_d = a_op & b_op;
      OP_OR:  out_d = a_op | b_op;
      OP_XOR: out_d = a_op ^ b_op;
      OP_ADD: begin
        out_d = sum[WIDTH-1:0];
        c_d   = sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not.
        v_d   = (a_op[WIDTH-1] == b_op[WIDTH-1]) &&
                (sum[WIDTH-1] != a_op[WIDTH-1]);
      end
      // Shifts use the raw operand: inversion, Cin and upper b bits are ignored.
      OP_SRL: out_d = a >> shamt;
      OP_SLL: out_d = a << shamt;
      default: out_d = '0;
    endcase
    status_d = {v_d, c_d, out_d[WIDTH-1], (out_d == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      c_q      <= 1'b0;
      status_q <= '0;
    end else begin
      out_q    <= out_d;
      c_q      <= c_d;
      status_q <= status_d;
    end
  end

  assign out    = out_q;
  assign cOut   = c_q;
  assign status = status_q;

endmodule

// File: tb/tb_alu_test2.sv
// tb_alu_test2 -- directed checks of alu_test2 with hand-computed expectations.
module tb_alu_test2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a   = '0;
  logic [63:0] b   = '0;
  logic        Cin = 1'b0;
  logic [4:0]  sel = '0;
  logic [63:0] out;
  logic        cOut;
  logic [3:0]  status;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  alu_test2 #(.WIDTH(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .Cin    (Cin),
    .sel    (sel),
    .out    (out),
    .cOut   (cOut),
    .status (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [63:0] e_out,
                            input logic e_c, input logic [3:0] e_st);
    check({tag, ".out"},    out,           e_out);
    check({tag, ".cOut"},   {63'd0, cOut}, {63'd0, e_c});
    check({tag, ".status"}, {60'd0, status}, {60'd0, e_st});
  endtask

  // Drive inputs on the falling edge, then sample just after the rising edge.
  task automatic op(input logic [63:0] ta, input logic [63:0] tb,
                    input logic [4:0] ts, input logic tc);
    @(negedge clk);
    a = ta; b = tb; sel = ts; Cin = tc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #1;
    expect_all("reset_async", 64'd0, 1'b0, 4'b0000);
    a = 64'd2; b = 64'd2; sel = 5'b10000; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_all("reset_held", 64'd0, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    op(64'd2, 64'd2, 5'b10000, 1'b0);
    expect_all("add_2_2", 64'd4, 1'b0, 4'b0000);

    op(64'd3, 64'd2, 5'b10010, 1'b1);
    expect_all("sub_3_2", 64'd1, 1'b1, 4'b0100);

    op(64'd2, 64'd4, 5'b10010, 1'b1);
    expect_all("sub_2_4", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b0010);

    op(64'd2, 64'd5, 5'b10001, 1'b1);
    expect_all("rsub_5_2", 64'd3, 1'b1, 4'b0100);

    op(64'd0, 64'd0, 5'b10000, 1'b0);
    expect_all("add_zero", 64'd0, 1'b0, 4'b0001);

    op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'b10000, 1'b0);
    expect_all("add_carry", 64'd0, 1'b1, 4'b0101);

    op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b10000, 1'b0);
    expect_all("add_ovf", 64'h8000_0000_0000_0000, 1'b0, 4'b1010);

    op(64'd3, 64'd4, 5'b00100, 1'b0);
    expect_all("or_3_4", 64'd7, 1'b0, 4'b0000);

    op(64'd2, 64'd5, 5'b01100, 1'b0);
    expect_all("xor_2_5", 64'd7, 1'b0, 4'b0000);

    op(64'd2, 64'd1, 5'b00000, 1'b0);
    expect_all("and_2_1", 64'd0, 1'b0, 4'b0001);

    op(64'd1, 64'd0, 5'b01110, 1'b0);
    expect_all("xor_1_notb", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 4'b0010);

    op(64'd23, 64'd3, 5'b10100, 1'b0);
    expect_all("srl_23_3", 64'd2, 1'b0, 4'b0000);

    op(64'd23, 64'd3, 5'b11000, 1'b0);
    expect_all("sll_23_3", 64'd184, 1'b0, 4'b0000);

    // Shift ignores inversion bits, Cin and b[63:6]
    op(64'd23, 64'hFFFF_FFFF_FFFF_FFC3, 5'b10111, 1'b1);
    expect_all("srl_ignore", 64'd2, 1'b0, 4'b0000);

    op(64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0);
    expect_all("srl_63", 64'd1, 1'b0, 4'b0000);

    op(64'd1, 64'd63, 5'b11000, 1'b0);
    expect_all("sll_63", 64'h8000_0000_0000_0000, 1'b0, 4'b0010);

    op(64'hFFFF, 64'hFFFF, 5'b01000, 1'b1);
    expect_all("nop_010", 64'd0, 1'b0, 4'b0001);

    op(64'hFFFF, 64'hFFFF, 5'b11100, 1'b1);
    expect_all("nop_111", 64'd0, 1'b0, 4'b0001);

    // Outputs hold between edges while inputs change
    op(64'd5, 64'd6, 5'b10000, 1'b0);
    expect_all("add_5_6", 64'd11, 1'b0, 4'b0000);
    @(negedge clk);
    a = 64'd100; b = 64'd200;
    #1;
    expect_all("hold", 64'd11, 1'b0, 4'b0000);

    // Mid-cycle reset clears at once; the first edge after release loads new inputs
    #1 rst = 1'b1;
    #1;
    expect_all("reset_mid", 64'd0, 1'b0, 4'b0000);
    #1 rst = 1'b0;
    a = 64'd9; b = 64'd1; sel = 5'b10000; Cin = 1'b0;
    @(posedge clk);
    #1;
    expect_all("after_reset", 64'd10, 1'b0, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
